// File: rtl/busdma_pkg.sv
// busdma_pkg: shared types and constants for the bus-master DMA engine.
//   state_e   - engine state encoding
//   ST_*      - completion status codes reported on `status`
//   M_*       - transfer mode codes sampled on `start`
//   align_hw / next_hw - halfword address helpers (26-bit byte addresses)
package busdma_pkg;

    localparam int AW = 26;
    localparam int DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FIN
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ABORT   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic M_COPY = 1'b0;
    localparam logic M_FILL = 1'b1;

    // Byte address of the halfword containing `a`.
    function automatic logic [AW-1:0] align_hw(input logic [AW-1:0] a);
        return a & ~26'h1;
    endfunction

    // Next halfword address; wraps modulo 2^26.
    function automatic logic [AW-1:0] next_hw(input logic [AW-1:0] a);
        return a + 26'd2;
    endfunction

endpackage

// File: rtl/busdma_buf.sv
// dma_buf: BURST x 16 staging buffer between the read and write phases of a
// copy chunk.
//   clk, reset  - clock, asynchronous active-low reset (pointers only)
//   clr_i       - return both pointers to entry 0 (start of a chunk)
//   we_i        - write wdata_i at the write pointer, then advance it
//   wdata_i     - data captured from the bus on a read completion
//   re_i        - advance the read pointer (a write access completed)
//   rdata_o     - combinational read of the entry at the read pointer
module dma_buf #(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        we_i,
    input  logic [15:0] wdata_i,
    input  logic        re_i,
    output logic [15:0] rdata_o
);

    // At least one pointer bit so BURST=1 still elaborates; pointers wrap
    // naturally because BURST is a power of two.
    localparam int PW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int DEPTH = 1 << PW;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (we_i) wptr_q <= wptr_q + 1'b1;
            if (re_i) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/busdma.sv
// busdma: bus-master DMA engine for one master port of the SDRAM hub.
// Copies `len` halfwords from src_addr to dst_addr in chunks of up to BURST
// (all reads of a chunk, then all writes), or fills dst with fill_data.
//   reset, clk            - asynchronous active-low reset, clock
//   start, mode, src_addr, dst_addr, len, fill_data - transfer request
//   abort                 - level request to stop at the next gap
//   busy, done, status    - progress / one-cycle completion / result code
//   cs, rd, wr, mask, addr, wdata - bus request outputs (all registered)
//   nwait, rdata          - bus completion and read data inputs
module busdma
    import busdma_pkg::*;
#(
    parameter int BURST   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          reset,
    input  logic          clk,
    input  logic          start,
    input  logic          mode,
    input  logic [25:0]   src_addr,
    input  logic [25:0]   dst_addr,
    input  logic [15:0]   len,
    input  logic [15:0]   fill_data,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic          cs,
    output logic          rd,
    output logic          wr,
    output logic [1:0]    mask,
    input  logic          nwait,
    output logic [25:0]   addr,
    output logic [15:0]   wdata,
    input  logic [15:0]   rdata
);

    localparam int CW = $clog2(BURST + 1);   // counts 0..BURST
    localparam int TW = $clog2(TIMEOUT + 1); // counts 0..TIMEOUT

    state_e        state_q;
    logic          mode_q;
    logic [25:0]   src_q;
    logic [25:0]   dst_q;
    logic [15:0]   rem_q;
    logic [15:0]   fill_q;
    logic [CW-1:0] cnt_q;     // accesses completed in the current phase
    logic [TW-1:0] tmo_q;     // nwait=0 cycles in the current access
    logic          busy_q;
    logic          done_q;
    logic [1:0]    status_q;
    logic          cs_q;
    logic          rd_q;
    logic          wr_q;
    logic [25:0]   addr_q;
    logic [15:0]   wdata_q;

    logic [15:0]   chunk_n;
    logic          chunk_last;
    logic          buf_we;
    logic          buf_re;
    logic          buf_clr;
    logic [15:0]   buf_rdata;

    assign chunk_n    = (rem_q < 16'(BURST)) ? rem_q : 16'(BURST);
    assign chunk_last = (16'(cnt_q) == chunk_n);

    assign buf_we  = (state_q == RD) && nwait;
    assign buf_re  = (state_q == WR) && nwait;
    assign buf_clr = (state_q == IDLE) || ((state_q == WR_GAP) && chunk_last);

    dma_buf #(.BURST(BURST)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (buf_clr),
        .we_i    (buf_we),
        .wdata_i (rdata),
        .re_i    (buf_re),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mode_q   <= M_COPY;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q   <= 1'b1;
                        status_q <= ST_OK;
                        mode_q   <= mode;
                        src_q    <= align_hw(src_addr);
                        dst_q    <= align_hw(dst_addr);
                        rem_q    <= len;
                        fill_q   <= fill_data;
                        cnt_q    <= '0;
                        tmo_q    <= '0;
                        if (abort) begin
                            state_q  <= FIN;
                            done_q   <= 1'b1;
                            status_q <= ST_ABORT;
                        end else if (len == 16'd0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (mode == M_FILL) begin
                            state_q <= WR;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= align_hw(dst_addr);
                            wdata_q <= fill_data;
                        end else begin
                            state_q <= RD;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= align_hw(src_addr);
                        end
                    end
                end

                // Strobes and addr/wdata stay frozen until nwait=1 or the
                // wait budget runs out.
                RD, WR: begin
                    if (nwait) begin
                        cs_q  <= 1'b0;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        tmo_q <= '0;
                        cnt_q <= cnt_q + 1'b1;
                        if (state_q == RD) begin
                            src_q   <= next_hw(src_q);
                            state_q <= RD_GAP;
                        end else begin
                            dst_q   <= next_hw(dst_q);
                            state_q <= WR_GAP;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        cs_q     <= 1'b0;
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        status_q <= ST_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                RD_GAP: begin
                    if (abort) begin
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        status_q <= ST_ABORT;
                    end else if (chunk_last) begin
                        // Buffer entry 0 is already valid: the write phase
                        // starts straight out of this gap cycle.
                        state_q <= WR;
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= dst_q;
                        wdata_q <= buf_rdata;
                    end else begin
                        state_q <= RD;
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= src_q;
                    end
                end

                WR_GAP: begin
                    if (abort) begin
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        status_q <= ST_ABORT;
                    end else if (chunk_last) begin
                        rem_q <= rem_q - chunk_n;
                        cnt_q <= '0;
                        if (rem_q == chunk_n) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (mode_q == M_FILL) begin
                            state_q <= WR;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= dst_q;
                            wdata_q <= fill_q;
                        end else begin
                            state_q <= RD;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= src_q;
                        end
                    end else begin
                        state_q <= WR;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= dst_q;
                        wdata_q <= (mode_q == M_FILL) ? fill_q : buf_rdata;
                    end
                end

                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;
    assign cs     = cs_q;
    assign rd     = rd_q;
    assign wr     = wr_q;
    assign mask   = 2'b00;
    assign addr   = addr_q;
    assign wdata  = wdata_q;

endmodule

// File: tb/tb_busdma.sv
// Self-checking bench for busdma: table-driven transfers plus random ones,
// checked against a chunk-level model of the bus access sequence, and a few
// hand-written sequences for reset, done/start overlap and abort/timeout.
module tb_busdma;

    localparam int BURST   = 4;
    localparam int TIMEOUT = 15;

    logic        reset = 1'b0;
    logic        clk   = 1'b0;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [25:0] src_addr = '0;
    logic [25:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [15:0] fill_data = '0;
    logic        abort = 1'b0;
    logic        busy, done, cs, rd, wr;
    logic [1:0]  status, mask;
    logic        nwait = 1'b0;
    logic [25:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata = '0;

    busdma #(.BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .reset(reset), .clk(clk), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .status(status), .cs(cs), .rd(rd), .wr(wr), .mask(mask),
        .nwait(nwait), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [25:0] a;
        logic [15:0] d;
    } acc_t;

    typedef struct {
        logic        mode;
        logic [25:0] src;
        logic [25:0] dst;
        logic [15:0] len;
        logic [15:0] fill;
        int          stall;
        int          abort_k;
        int          hold;
        logic [1:0]  exp_status;
        int          exp_lat;
        int          exp_cnt;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Bench-side memory contents: a fixed function of the address.
    function automatic logic [15:0] mem_val(input logic [25:0] a);
        return a[16:1] ^ {a[25:18], a[8:1]} ^ 16'h3C5A;
    endfunction

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- memory model / bus monitor ----------------
    acc_t        acc_q[$];
    int          max_stall = 0;
    bit          hold_forever = 1'b0;
    bit          mon_en = 1'b1;
    int          xfer_id = 0;
    int          seen_id = 0;
    int          mon_err = 0;
    int          drop_cycles = -1;
    bit          in_acc = 1'b0;
    bit          cmp_pend = 1'b0;
    bit          seen_cmp = 1'b0;
    int          gap_cnt = 0;
    int          stall_left = 0;
    int          acc_cycles = 0;
    logic [25:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_wr;

    always @(negedge clk) begin
        if (seen_id != xfer_id) begin
            seen_id = xfer_id;
            acc_q.delete();
            seen_cmp = 1'b0;
            gap_cnt = 0;
            drop_cycles = -1;
        end
        if (cmp_pend) begin
            in_acc = 1'b0; cmp_pend = 1'b0; seen_cmp = 1'b1; gap_cnt = 0;
        end
        if (cs && (rd || wr)) begin
            if (!in_acc) begin
                if (mon_en && seen_cmp && gap_cnt != 1) begin
                    $display("FAIL gap_len: got %0d, expected 1", gap_cnt); mon_err++;
                end
                if (mon_en && mask != 2'b00) begin
                    $display("FAIL mask: got %0b, expected 00", mask); mon_err++;
                end
                in_acc = 1'b1; acc_cycles = 0;
                acc_addr = addr; acc_wdata = wdata; acc_wr = wr;
                stall_left = hold_forever ? 1000000 : $urandom_range(0, max_stall);
            end else if (mon_en) begin
                if (addr != acc_addr) begin
                    $display("FAIL addr_hold: got %0h, expected %0h", addr, acc_addr); mon_err++;
                end
                if (acc_wr && wdata != acc_wdata) begin
                    $display("FAIL wdata_hold: got %0h, expected %0h", wdata, acc_wdata); mon_err++;
                end
            end
            acc_cycles++;
            if (stall_left == 0) begin
                nwait = 1'b1;
                rdata = mem_val(addr);
                cmp_pend = 1'b1;
                acc_q.push_back({acc_wr, addr, acc_wr ? wdata : mem_val(addr)});
            end else begin
                nwait = 1'b0;
                stall_left--;
                rdata = 16'($urandom);
            end
        end else begin
            nwait = 1'b0;
            if (in_acc) begin
                in_acc = 1'b0;
                drop_cycles = acc_cycles;
            end
            gap_cnt++;
        end
    end

    // ---------------- reference model ----------------
    acc_t exp_q[$];

    function automatic void build_exp(input vec_t v);
        logic [25:0] s, d;
        int rem, n;
        acc_t e;
        exp_q.delete();
        s = v.src & ~26'h1;
        d = v.dst & ~26'h1;
        rem = int'(v.len);
        while (rem > 0) begin
            n = (rem < BURST) ? rem : BURST;
            if (v.mode == 1'b0) begin
                for (int i = 0; i < n; i++) begin
                    e.w = 1'b0; e.a = s + 26'(2 * i); e.d = mem_val(e.a);
                    exp_q.push_back(e);
                end
                for (int i = 0; i < n; i++) begin
                    e.w = 1'b1; e.a = d + 26'(2 * i); e.d = mem_val(s + 26'(2 * i));
                    exp_q.push_back(e);
                end
                s = s + 26'(2 * n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    e.w = 1'b1; e.a = d + 26'(2 * i); e.d = v.fill;
                    exp_q.push_back(e);
                end
            end
            d = d + 26'(2 * n);
            rem -= n;
        end
    endfunction

    function automatic vec_t mk(input logic md, input logic [25:0] s, input logic [25:0] d,
                                input logic [15:0] l, input logic [15:0] f, input int st,
                                input int ak, input int hd, input logic [1:0] es,
                                input int el, input int ec);
        vec_t v;
        v.mode = md; v.src = s; v.dst = d; v.len = l; v.fill = f; v.stall = st;
        v.abort_k = ak; v.hold = hd; v.exp_status = es; v.exp_lat = el; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic run_xfer(input vec_t v, input string nm);
        int  k;
        bit  got;
        int  err0;
        build_exp(v);
        if (v.exp_cnt >= 0)
            while (exp_q.size() > v.exp_cnt) void'(exp_q.pop_back());
        max_stall = v.stall;
        hold_forever = (v.hold != 0);
        err0 = mon_err;
        @(negedge clk);
        mode = v.mode; src_addr = v.src; dst_addr = v.dst; len = v.len;
        fill_data = v.fill; start = 1'b1; xfer_id++;
        k = 0; got = 1'b0;
        while (!got && k < 3000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (v.abort_k == k) abort = 1'b1;
            if (k == 1) chk_eq({nm, ".busy"}, 64'(busy), 64'd1);
            if (done) got = 1'b1;
        end
        abort = 1'b0;
        chk_eq({nm, ".done_seen"}, 64'(got), 64'd1);
        if (v.exp_lat > 0) chk_eq({nm, ".latency"}, 64'(k), 64'(v.exp_lat));
        chk_eq({nm, ".status"}, 64'(status), 64'(v.exp_status));
        @(negedge clk);
        hold_forever = 1'b0;
        chk_eq({nm, ".idle_after"}, 64'({busy, done, cs}), 64'd0);
        chk_eq({nm, ".status_hold"}, 64'(status), 64'(v.exp_status));
        if (v.hold != 0) chk_eq({nm, ".strobe_cycles"}, 64'(drop_cycles), 64'(TIMEOUT));
        chk_eq({nm, ".n_acc"}, 64'(acc_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk_eq($sformatf("%s.acc%0d", nm, i), 64'(acc_q[i]), 64'(exp_q[i]));
        chk_eq({nm, ".bus_protocol"}, 64'(mon_err - err0), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        vec_t rv;

        vecs[0] = mk(1'b0, 26'h100,     26'h2000, 16'd6, 16'h0000, 0, 0, 0, 2'd0, 25, -1);
        vecs[1] = mk(1'b1, 26'h0,       26'h3FFFFFC, 16'd3, 16'hA5A5, 0, 0, 0, 2'd0, 7, -1);
        vecs[2] = mk(1'b0, 26'h1000,    26'h8000, 16'd9, 16'h0000, 7, 0, 0, 2'd0, -1, -1);
        vecs[3] = mk(1'b0, 26'h100,     26'h2000, 16'd6, 16'h0000, 0, 3, 0, 2'd1, 5, 2);
        vecs[4] = mk(1'b0, 26'h500,     26'h600,  16'd4, 16'h0000, 0, 0, 1, 2'd2, 16, 0);
        vecs[5] = mk(1'b0, 26'h700,     26'h800,  16'd0, 16'h0000, 0, 0, 0, 2'd0, 1, -1);
        vecs[6] = mk(1'b0, 26'h201,     26'h3001, 16'd4, 16'h0000, 0, 0, 0, 2'd0, 17, -1);
        vecs[7] = mk(1'b1, 26'h0,       26'h4000, 16'd5, 16'h1234, 3, 0, 0, 2'd0, -1, -1);
        vecs[8] = mk(1'b1, 26'h0,       26'h5000, 16'd8, 16'h0F0F, 0, 0, 0, 2'd0, 17, -1);

        // Reset state
        #1;
        chk_eq("reset.outputs",
               64'({busy, done, status, cs, rd, wr, mask, addr, wdata}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rv.mode = 1'($urandom_range(0, 1));
            rv.src = 26'($urandom);
            rv.dst = 26'($urandom);
            rv.len = 16'($urandom_range(1, 12));
            rv.fill = 16'($urandom);
            rv.stall = $urandom_range(0, 1) * 7;
            rv.abort_k = 0; rv.hold = 0; rv.exp_status = 2'd0; rv.exp_cnt = -1;
            rv.exp_lat = (rv.stall != 0) ? -1 :
                         (rv.mode ? 2 * int'(rv.len) + 1 : 4 * int'(rv.len) + 1);
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        // start during done is ignored, start one cycle later is accepted
        max_stall = 0;
        @(negedge clk);
        mode = 1'b0; src_addr = 26'h10; dst_addr = 26'h20; len = 16'd1;
        start = 1'b1; xfer_id++;
        k = 0;
        @(negedge clk); start = 1'b0;
        while (!done && k < 50) begin @(negedge clk); k++; end
        chk_eq("overlap.done_seen", 64'(done), 64'd1);
        len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("overlap.start_ignored", 64'({busy, done}), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("overlap.start_accepted", 64'({busy, done}), 64'b11);
        @(negedge clk);
        chk_eq("overlap.back_idle", 64'({busy, done}), 64'd0);

        // asynchronous reset in the middle of a write access
        hold_forever = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        mode = 1'b1; dst_addr = 26'h40; len = 16'd4; fill_data = 16'hBEEF;
        start = 1'b1; xfer_id++;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!wr && k < 20) begin @(negedge clk); k++; end
        chk_eq("rst.write_active", 64'({cs, wr, addr, wdata}), 64'({2'b11, 26'h40, 16'hBEEF}));
        #2 reset = 1'b0;
        #1;
        chk_eq("rst.outputs",
               64'({busy, done, status, cs, rd, wr, mask, addr, wdata}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        hold_forever = 1'b0;
        mon_en = 1'b1;
        run_xfer(vecs[1], "recover");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/busdma.md
# busdma

Bus-master DMA engine that drives one master port of the dual-master SDRAM hub: the initiator side of the `cs/rd/wr/mask/nwait/addr/wdata/rdata` bus. It copies a block of halfwords between two SDRAM byte addresses, or fills a block with a constant, so CPU-side masters are relieved of bulk transfers. It sits between the register file, which supplies configuration and start, and bus port B of the hub.

## Interface
- `BURST`, default 4: halfwords buffered per read/write chunk. Power of 2, range 1..16.
- `TIMEOUT`, default 1023: maximum consecutive cycles with `nwait=0` in one access before the engine flags an error.

Ports, clock and reset first:
- `reset` in 1: asynchronous, active-low.
- `clk` in 1: clock.
- `start` in 1: one-cycle pulse that starts a transfer. Ignored while `busy`.
- `mode` in 1: 0 = copy, 1 = fill. Sampled on `start`.
- `src_addr` in 26: source byte address. Bit 0 is forced to 0. Sampled on `start`.
- `dst_addr` in 26: destination byte address. Bit 0 is forced to 0. Sampled on `start`.
- `len` in 16: transfer length in halfwords. 0 means no access. Sampled on `start`.
- `fill_data` in 16: fill value. Sampled on `start`.
- `abort` in 1: level input. Requests an early stop.
- `busy` out 1: high from the cycle after `start` until the cycle `done` pulses.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: valid from `done` until the next `start`. 0 = ok, 1 = aborted, 2 = timeout.
- `cs`, `rd`, `wr` out 1 each: bus strobes.
- `mask` out 2: byte mask, 1 = byte disabled. Always 2'b00.
- `nwait` in 1: 1 = the current access completes on this edge.
- `addr` out 26: byte address.
- `wdata` out 16: write data.
- `rdata` in 16: read data.

## Operation
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE + `start`:
  - Latch all configuration inputs and clear `status`.
  - If `len==0`, go to FIN.
  - Otherwise go to RD in copy mode, or WR in fill mode.
- Chunking: chunk size is `n = min(BURST, remaining)`.
  - Copy: RD issues `n` reads into the buffer, then WR issues `n` writes from it.
  - Fill: WR issues `n` writes of `fill_data`.
  - `remaining -= n` after each chunk's last write. Go to FIN when `remaining==0`.
- Access rule: while `cs=1` with `rd` or `wr` high, `addr` and `wdata` are held stable. The access completes on the first rising edge with `nwait=1`; `rdata` is captured on that edge.
- After each completed access, the next state is RD_GAP or WR_GAP. That state drives `cs=rd=wr=0` for exactly 1 cycle, so the hub sees a fresh request edge.
- Addresses: `src` and `dst` advance by 2 after each completed access. They wrap modulo 2^26: 26'h3FFFFFE + 2 = 0.
- Abort:
  - Checked only in IDLE, RD_GAP and WR_GAP.
  - An in-flight access is never dropped.
  - A gap state that sees `abort=1` goes to FIN with `status=1`. Buffered but unwritten data is discarded.
- Timeout: count `nwait=0` cycles within one access. When the count reaches TIMEOUT:
  - Deassert strobes.
  - Go to FIN with `status=2`.
- FIN: pulse `done`, clear `busy`, return to IDLE.
- Reset values: `busy=0`, `done=0`, `status=0`, `cs=rd=wr=0`, `mask=0`, `addr=0`, `wdata=0`, state=IDLE.
- Reset asserted mid-access forces all outputs to these values immediately; the transfer is lost.

## Timing
- `start` at edge T means the first strobe is driven in cycle T+1. With `len=0`, `done` pulses in cycle T+1.
- A zero-wait access occupies 2 cycles: 1 strobe cycle plus 1 gap cycle.
  - Copy of `N` halfwords with zero wait states takes 4N cycles from the first strobe to the last gap, then `done` follows 1 cycle later.
  - Fill of `N` halfwords takes 2N cycles, then `done`.
- Read→write turnaround within a chunk is only the normal gap cycle. There is no extra bubble.
- `start` pulses in the same cycle as `done` are ignored, because the engine is still busy. A `start` in the cycle after `done` is accepted.

## Structure
- Package `busdma_pkg` holds:
  - the state enum;
  - status codes ST_OK=0, ST_ABORT=1, ST_TIMEOUT=2;
  - mode codes M_COPY=0, M_FILL=1.
- Sub-module `dma_buf`: a BURST×16 register buffer with a write pointer, a read pointer and a clear input. It is written on read-completion edges and read combinationally for `wdata`.
- Control, address counters and the timeout counter live in `busdma`.

## Test plan
- Copy `len=6`, src=0x100, dst=0x2000, zero-wait memory model:
  - Reads 0x100..0x10A, then writes 0x2000..0x200A.
  - Chunks are 4 then 2.
  - Data matches; `done` arrives 25 cycles after `start`; `status=0`.
- Fill `len=3`, dst=0x3FFFFFC, `fill_data`=0xA5A5: writes land at 0x3FFFFFC, 0x3FFFFFE, 0x0000000 (wrap), each with `mask=00`.
- Random `nwait` stalls of 0..7 cycles on a copy with `len=9`: `addr` and `wdata` stay stable through every stall, there is exactly one gap cycle per access, and the data is correct.
- Assert `abort` during the 2nd read of chunk 1: that read completes, there are no writes, and `done` pulses with `status=1`.
- Hold `nwait=0` on the first read with TIMEOUT=15: strobes drop after 15 cycles, then `done` pulses with `status=2`.
- `len=0`: `done` pulses 1 cycle after `start` with no bus activity. Separately, reset asserted mid-write returns all outputs to their reset values at once.
